// File: rtl/record_pkg.sv
// Shared types for the record byte link (packer and unpacker sides).
// RECORD_UNPACKER_PARITY_EN appends a XOR parity byte to every frame.
package record_pkg;

    typedef struct packed {
        logic [9:0]  a;
        logic [9:0]  aa;
        int unsigned aaa;
    } record_t;

    typedef enum logic [1:0] {
        KIND_X = 2'd1,
        KIND_Y = 2'd2,
        KIND_Z
    } kind_t;

    typedef enum logic [2:0] {
        S_HDR,
        S_A0,
        S_A1,
        S_AA0,
        S_AA1,
        S_AAA,
        S_PAR
    } state_t;

`ifdef RECORD_UNPACKER_PARITY_EN
    localparam int FRAME_BYTES = 10;
`else
    localparam int FRAME_BYTES = 9;
`endif

    localparam int REC_W = $bits(record_t);

endpackage

// File: rtl/record_out_reg.sv
// Single-entry valid/ready holding register. A load always wins over a take,
// so a record arriving in the same cycle the old one is consumed keeps valid high.
module record_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         take,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    // Hold one entry; load sets valid, a consumer take clears it.
    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (take) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/record_unpacker.sv
// Byte-link receiver: rebuilds record_t + kind_t from a little-endian byte
// frame and presents it on a valid/ready port.
// RECORD_UNPACKER_PARITY_EN adds a trailing XOR parity byte (state S_PAR).
module record_unpacker
    import record_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_byte,
    input  logic             i_valid,
    output logic             o_ready,
    output record_t          o_rec,
    output kind_t            o_kind,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_err,
    output logic [CNT_W-1:0] o_frame_cnt
);

    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TO_EN  = (TIMEOUT > 0);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_reg, state_next;
    logic [1:0]        bcnt_reg, bcnt_next;
    record_t           shadow_reg, shadow_next;
    kind_t             kind_reg, kind_next;
    logic [IDLE_W-1:0] idle_reg, idle_next;
    logic              err_reg, err_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              final_pos, stall, accept, load;
    logic [REC_W+1:0]  out_data;
`ifdef RECORD_UNPACKER_PARITY_EN
    logic [7:0]        par_reg, par_next;

    assign final_pos = (state_reg == S_PAR);
`else
    assign final_pos = (state_reg == S_AAA) && (bcnt_reg == 2'd3);
`endif

    // Only the completing byte is held off while the output slot is full.
    assign stall   = final_pos && o_valid && !i_ready;
    assign o_ready = !i_rst && !stall;
    assign accept  = i_valid && o_ready;

    // Next-state, field accumulation, idle timeout and error detection.
    always_comb begin
        state_next  = state_reg;
        bcnt_next   = bcnt_reg;
        shadow_next = shadow_reg;
        kind_next   = kind_reg;
        idle_next   = idle_reg;
        err_next    = 1'b0;
        load        = 1'b0;
`ifdef RECORD_UNPACKER_PARITY_EN
        par_next    = par_reg;
`endif
        if (accept) begin
            idle_next = '0;
`ifdef RECORD_UNPACKER_PARITY_EN
            par_next  = par_reg ^ i_byte;
`endif
            case (state_reg)
                S_HDR: begin
                    if (i_byte[1:0] == 2'd0) begin
                        err_next = 1'b1;
                    end else begin
                        kind_next  = kind_t'(i_byte[1:0]);
                        state_next = S_A0;
`ifdef RECORD_UNPACKER_PARITY_EN
                        par_next   = i_byte;
`endif
                    end
                end
                S_A0: begin
                    shadow_next.a[7:0] = i_byte;
                    state_next         = S_A1;
                end
                S_A1: begin
                    shadow_next.a[9:8] = i_byte[1:0];
                    state_next         = S_AA0;
                end
                S_AA0: begin
                    shadow_next.aa[7:0] = i_byte;
                    state_next          = S_AA1;
                end
                S_AA1: begin
                    shadow_next.aa[9:8] = i_byte[1:0];
                    bcnt_next           = 2'd0;
                    state_next          = S_AAA;
                end
                S_AAA: begin
                    for (int i = 0; i < 4; i++) begin
                        if (bcnt_reg == 2'(i)) begin
                            shadow_next.aaa[8*i +: 8] = i_byte;
                        end
                    end
                    bcnt_next = bcnt_reg + 2'd1;
                    if (bcnt_reg == 2'd3) begin
`ifdef RECORD_UNPACKER_PARITY_EN
                        state_next = S_PAR;
`else
                        state_next = S_HDR;
                        load       = 1'b1;
`endif
                    end
                end
`ifdef RECORD_UNPACKER_PARITY_EN
                S_PAR: begin
                    state_next = S_HDR;
                    if (par_reg == i_byte) begin
                        load = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
`endif
                default: state_next = S_HDR;
            endcase
        end else if (state_reg != S_HDR && !stall && TO_EN) begin
            if (idle_reg == IDLE_MAX) begin
                state_next = S_HDR;
                idle_next  = '0;
                err_next   = 1'b1;
            end else begin
                idle_next = idle_reg + 1'b1;
            end
        end
    end

    // State, shadow record, idle counter, error pulse and delivered-frame count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= S_HDR;
            bcnt_reg   <= '0;
            shadow_reg <= '0;
            kind_reg   <= kind_t'(2'd0);
            idle_reg   <= '0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
`ifdef RECORD_UNPACKER_PARITY_EN
            par_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            bcnt_reg   <= bcnt_next;
            shadow_reg <= shadow_next;
            kind_reg   <= kind_next;
            idle_reg   <= idle_next;
            err_reg    <= err_next;
            if (load) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
`ifdef RECORD_UNPACKER_PARITY_EN
            par_reg    <= par_next;
`endif
        end
    end

    record_out_reg #(
        .W(REC_W + 2)
    ) u_out (
        .clk       (i_clk),
        .srst      (i_rst),
        .load      (load),
        .load_data ({shadow_next, kind_next}),
        .take      (i_ready),
        .valid     (o_valid),
        .data      (out_data)
    );

    assign o_rec       = record_t'(out_data[REC_W+1:2]);
    assign o_kind      = kind_t'(out_data[1:0]);
    assign o_err       = err_reg;
    assign o_frame_cnt = cnt_reg;

endmodule
